// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: opcode encoding, datapath widths,
// and the 6-bit result function used by the shared ALU.
package alu_share_pkg;

    localparam int ALU_RES_W  = 6;
    localparam int ALU_OPND_W = 4;

    typedef enum logic [3:0] {
        OP_INC_A  = 4'b0000,
        OP_DEC_A  = 4'b0001,
        OP_SHL1_A = 4'b0010,
        OP_INC_B  = 4'b0011,
        OP_DEC_B  = 4'b0100,
        OP_SHL1_B = 4'b0101,
        OP_ADD    = 4'b0110,
        OP_SHL2_A = 4'b0111,
        OP_NOT_A  = 4'b1000,
        OP_NOT_B  = 4'b1001,
        OP_AND    = 4'b1010,
        OP_OR     = 4'b1011,
        OP_XOR    = 4'b1100,
        OP_XNOR   = 4'b1101,
        OP_NAND   = 4'b1110,
        OP_NOR    = 4'b1111
    } alu_op_t;

    // Arithmetic ops work on sign-extended operands; logic ops stay 4 bits and zero-extend.
    function automatic logic [ALU_RES_W-1:0] alu_eval(
        input alu_op_t                op,
        input logic [ALU_OPND_W-1:0]  a,
        input logic [ALU_OPND_W-1:0]  b
    );
        logic [ALU_RES_W-1:0]  sa;
        logic [ALU_RES_W-1:0]  sb;
        logic [ALU_RES_W-1:0]  ar;
        logic [ALU_OPND_W-1:0] lr;
        sa = {{(ALU_RES_W-ALU_OPND_W){a[ALU_OPND_W-1]}}, a};
        sb = {{(ALU_RES_W-ALU_OPND_W){b[ALU_OPND_W-1]}}, b};
        ar = '0;
        lr = '0;
        case (op)
            OP_INC_A:  ar = sa + 6'd1;
            OP_DEC_A:  ar = sa - 6'd1;
            OP_SHL1_A: ar = sa << 1;
            OP_INC_B:  ar = sb + 6'd1;
            OP_DEC_B:  ar = sb - 6'd1;
            OP_SHL1_B: ar = sb << 1;
            OP_ADD:    ar = sa + sb;
            OP_SHL2_A: ar = sa << 2;
            OP_NOT_A:  lr = ~a;
            OP_NOT_B:  lr = ~b;
            OP_AND:    lr = a & b;
            OP_OR:     lr = a | b;
            OP_XOR:    lr = a ^ b;
            OP_XNOR:   lr = ~(a ^ b);
            OP_NAND:   lr = ~(a & b);
            OP_NOR:    lr = ~(a | b);
            default:   ar = '0;
        endcase
        return op[3] ? {{(ALU_RES_W-ALU_OPND_W){1'b0}}, lr} : ar;
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after ptr,
// wrapping modulo NREQ, so the last winner has lowest priority next time.
module alu_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one 4-bit ALU among NREQ requesters with a single
// registered, backpressured response port. Optional stall counter: ALU_SHARE_STALL_CNT_EN.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [ALU_OPND_W*NREQ-1:0] req_sel,
    input  logic [ALU_OPND_W*NREQ-1:0] req_a,
    input  logic [ALU_OPND_W*NREQ-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ALU_RES_W-1:0]       rsp_y,
`ifdef ALU_SHARE_STALL_CNT_EN
    output logic [15:0]                stall_cnt,
`endif
    output logic [ID_W-1:0]            rsp_id
);

    // Handshake: a transfer happens on a cycle where valid && ready are both high
    // at the rising edge. req_ready is combinational from req_valid, so requesters
    // must never wait on req_ready before raising req_valid; rsp_y/rsp_id are held
    // while rsp_valid && !rsp_ready.

    logic [ID_W-1:0]       ptr;
    logic                  can_acc;
    logic [NREQ-1:0]       grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  any_grant;
    logic                  fire;
    logic [ALU_OPND_W-1:0] sel_g;
    logic [ALU_OPND_W-1:0] a_g;
    logic [ALU_OPND_W-1:0] b_g;
    logic [ALU_RES_W-1:0]  y_next;

    assign can_acc   = !rsp_valid || rsp_ready;
    assign req_ready = can_acc ? grant : '0;
    assign fire      = can_acc && any_grant;

    alu_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // One-hot AND-OR operand mux avoids out-of-range slices when NREQ is not a power of two.
    always_comb begin
        sel_g = '0;
        a_g   = '0;
        b_g   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_g = sel_g | req_sel[ALU_OPND_W*i +: ALU_OPND_W];
                a_g   = a_g   | req_a[ALU_OPND_W*i +: ALU_OPND_W];
                b_g   = b_g   | req_b[ALU_OPND_W*i +: ALU_OPND_W];
            end
        end
    end

    assign y_next = alu_eval(alu_op_t'(sel_g), a_g, b_g);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            ptr       <= ID_W'(NREQ - 1);
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_y     <= y_next;
            rsp_id    <= grant_idx;
            ptr       <= grant_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SHARE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((|req_valid) && !can_acc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
